// File: rtl/display_frame_reader_pkg.sv
// Shared types and field layout for the display read path (package display_pkg).
// The packed word carries a 10-bit channel in [9:0] and 5 green bits in [14:10].
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    localparam int B_LSB   = 0;
    localparam int B_MSB   = 9;
    localparam int GHI_LSB = 10;
    localparam int GHI_MSB = 14;
    localparam int PIX_W   = 10;
    localparam int WORD_W  = 16;
    localparam int COORD_W = 16;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef struct packed {
        logic [PIX_W-1:0] red;
        logic [PIX_W-1:0] green;
        logic [PIX_W-1:0] blue;
    } rgb_t;

endpackage

// File: rtl/display_frame_reader_if.sv
// FIFO read side and pixel output bundle of the display frame reader.
// master = the reader itself, slave = the FIFOs/VGA controller around it.
interface display_frame_reader_if;
    import display_pkg::*;

    logic                  iFrameStart;
    logic                  iPixelReq;
    logic [WORD_W-1:0]     iRd1_data;
    logic [WORD_W-1:0]     iRd2_data;
    logic                  iRd1_empty;
    logic                  iRd2_empty;
    logic                  oRd1_req;
    logic                  oRd2_req;
    logic [PIX_W-1:0]      oRed;
    logic [PIX_W-1:0]      oGreen;
    logic [PIX_W-1:0]      oBlue;
    logic                  oValid;
    logic [COORD_W-1:0]    oX_Cont;
    logic [COORD_W-1:0]    oY_Cont;
    logic                  oFrameDone;
    logic                  oUnderflow;

    modport master (
        input  iFrameStart, iPixelReq, iRd1_data, iRd2_data, iRd1_empty, iRd2_empty,
        output oRd1_req, oRd2_req, oRed, oGreen, oBlue, oValid,
               oX_Cont, oY_Cont, oFrameDone, oUnderflow
    );

    modport slave (
        output iFrameStart, iPixelReq, iRd1_data, iRd2_data, iRd1_empty, iRd2_empty,
        input  oRd1_req, oRd2_req, oRed, oGreen, oBlue, oValid,
               oX_Cont, oY_Cont, oFrameDone, oUnderflow
    );

endinterface

// File: rtl/display_frame_reader_unpack.sv
// Registered unpack of two FIFO words into 10-bit RGB (module pixel_unpack).
// With UNDERFLOW_REPEAT_EN an underflowed pixel repeats the last good RGB; otherwise it is black.
module pixel_unpack
    import display_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_p0,
    input  logic              under_p0,
    input  logic [WORD_W-1:0] rd1_p0,
    input  logic [WORD_W-1:0] rd2_p0,
    output rgb_t              rgb_p1
);

    function automatic rgb_t unpack(input logic [WORD_W-1:0] w1, input logic [WORD_W-1:0] w2);
        rgb_t p;
        p.blue  = w1[B_MSB:B_LSB];
        p.red   = w2[B_MSB:B_LSB];
        p.green = {w1[GHI_MSB:GHI_LSB], w2[GHI_MSB:GHI_LSB]};
        return p;
    endfunction

    // Bit 15 of both words carries nothing for the display.
    logic unused_msb;
    assign unused_msb = rd1_p0[WORD_W-1] ^ rd2_p0[WORD_W-1];

    // p0 -> p1: FIFO words arrive one cycle after the pop and are registered here
`ifdef UNDERFLOW_REPEAT_EN
    rgb_t last_rgb;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_p1   <= '0;
            last_rgb <= '0;
        end else if (vld_p0) begin
            if (under_p0) begin
                rgb_p1 <= last_rgb;
            end else begin
                rgb_p1   <= unpack(rd1_p0, rd2_p0);
                last_rgb <= unpack(rd1_p0, rd2_p0);
            end
        end else begin
            rgb_p1 <= '0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_p1 <= '0;
        end else if (vld_p0 && !under_p0) begin
            rgb_p1 <= unpack(rd1_p0, rd2_p0);
        end else begin
            rgb_p1 <= '0;
        end
    end
`endif

endmodule

// File: rtl/display_frame_reader.sv
// Pops paired pixel words from two SDRAM read FIFOs on display request and emits RGB with X/Y.
// Optional macro UNDERFLOW_REPEAT_EN: underflowed pixels repeat the last good colour instead of black.
module display_frame_reader
    import display_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic                  iClk,
    input  logic                  iRst,
    display_frame_reader_if.master bus
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

    state_t               state;
    logic [COORD_W-1:0]   x_cnt;
    logic [COORD_W-1:0]   y_cnt;
    logic                 underflow_q;

    logic                 issue;
    logic                 pop;
    logic                 last_pix;

    logic                 vld_p0;
    logic                 under_p0;
    logic                 done_p0;
    logic [COORD_W-1:0]   x_p0;
    logic [COORD_W-1:0]   y_p0;

    logic                 vld_p1;
    logic                 done_p1;
    logic [COORD_W-1:0]   x_p1;
    logic [COORD_W-1:0]   y_p1;
    rgb_t                 rgb_p1;

    // Every request while streaming is a pixel slot, even if the FIFOs cannot supply it.
    assign issue    = bus.iPixelReq && (state == STREAM);
    assign pop      = issue && !bus.iRd1_empty && !bus.iRd2_empty;
    assign last_pix = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    assign bus.oRd1_req = pop;
    assign bus.oRd2_req = pop;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state       <= IDLE;
            x_cnt       <= '0;
            y_cnt       <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (issue && !pop) begin
                underflow_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.iFrameStart) begin
                        state <= STREAM;
                        x_cnt <= '0;
                        y_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (bus.iFrameStart) begin
                        x_cnt <= '0;
                        y_cnt <= '0;
                    end else if (issue) begin
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                        if (last_pix) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.iFrameStart) begin
                        state <= STREAM;
                        x_cnt <= '0;
                        y_cnt <= '0;
                    end else if (done_p1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p0: issue registered alongside its coordinates while the FIFO word is fetched
    // p1: coordinates aligned with the unpacked colour; a resync kills the pending frame-done
    always_ff @(posedge iClk) begin
        if (iRst) begin
            vld_p0   <= 1'b0;
            under_p0 <= 1'b0;
            done_p0  <= 1'b0;
            x_p0     <= '0;
            y_p0     <= '0;
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
            x_p1     <= '0;
            y_p1     <= '0;
        end else begin
            vld_p0   <= issue;
            under_p0 <= issue && !pop;
            done_p0  <= issue && last_pix && !bus.iFrameStart;
            x_p0     <= x_cnt;
            y_p0     <= y_cnt;
            vld_p1   <= vld_p0;
            done_p1  <= done_p0 && !bus.iFrameStart;
            x_p1     <= x_p0;
            y_p1     <= y_p0;
        end
    end

    pixel_unpack u_unpack (
        .clk      (iClk),
        .rst      (iRst),
        .vld_p0   (vld_p0),
        .under_p0 (under_p0),
        .rd1_p0   (bus.iRd1_data),
        .rd2_p0   (bus.iRd2_data),
        .rgb_p1   (rgb_p1)
    );

    assign bus.oRed       = rgb_p1.red;
    assign bus.oGreen     = rgb_p1.green;
    assign bus.oBlue      = rgb_p1.blue;
    assign bus.oValid     = vld_p1;
    assign bus.oX_Cont    = x_p1;
    assign bus.oY_Cont    = y_p1;
    assign bus.oFrameDone = done_p1;
    assign bus.oUnderflow = underflow_q;

endmodule

// File: tb/tb_display_frame_reader.sv
// Directed bench: a full-size 640x480 reader and a 4x2 reader share the same stimulus.
module tb_display_frame_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        pixel_req;
    logic [15:0] rd1_data;
    logic [15:0] rd2_data;
    logic        rd1_empty;
    logic        rd2_empty;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    display_frame_reader_if bus_f();
    display_frame_reader_if bus_s();

    assign bus_f.iFrameStart = frame_start;
    assign bus_f.iPixelReq   = pixel_req;
    assign bus_f.iRd1_data   = rd1_data;
    assign bus_f.iRd2_data   = rd2_data;
    assign bus_f.iRd1_empty  = rd1_empty;
    assign bus_f.iRd2_empty  = rd2_empty;

    assign bus_s.iFrameStart = frame_start;
    assign bus_s.iPixelReq   = pixel_req;
    assign bus_s.iRd1_data   = rd1_data;
    assign bus_s.iRd2_data   = rd2_data;
    assign bus_s.iRd1_empty  = rd1_empty;
    assign bus_s.iRd2_empty  = rd2_empty;

    display_frame_reader #(.H_ACTIVE(640), .V_ACTIVE(480)) dut_f (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus_f.master)
    );

    display_frame_reader #(.H_ACTIVE(4), .V_ACTIVE(2)) dut_s (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus_s.master)
    );

    // 16'h1234 / 16'h4321 unpack to red 321, green {00100,10000}=090, blue 234
    localparam logic [29:0] RGB_1234 = {10'h321, 10'h090, 10'h234};

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        pixel_req = 1'b0;
        rd1_data = '0;
        rd2_data = '0;
        rd1_empty = 1'b0;
        rd2_empty = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus_f.oValid, bus_f.oFrameDone, bus_f.oUnderflow, bus_f.oRd1_req, bus_f.oRd2_req} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus_f.oValid, bus_f.oFrameDone, bus_f.oUnderflow, bus_f.oRd1_req, bus_f.oRd2_req});
        else n_pass++;
        n_checks++;
        if ({bus_f.oRed, bus_f.oGreen, bus_f.oBlue} !== 30'h0)
            $display("FAIL reset_rgb: got %h want 0", {bus_f.oRed, bus_f.oGreen, bus_f.oBlue});
        else n_pass++;
        n_checks++;
        if ({bus_f.oX_Cont, bus_f.oY_Cont} !== 32'h0)
            $display("FAIL reset_xy: got %h want 0", {bus_f.oX_Cont, bus_f.oY_Cont});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unpack();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        rd1_data = 16'h7FFF;
        rd2_data = 16'h0000;
        pixel_req = 1'b1;
        #1;
        n_checks++;
        if ({bus_f.oRd1_req, bus_f.oRd2_req} !== 2'b11)
            $display("FAIL unpack_pop: got %b want 11", {bus_f.oRd1_req, bus_f.oRd2_req});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus_f.oValid !== 1'b0)
            $display("FAIL unpack_latency1: got valid %b want 0", bus_f.oValid);
        else n_pass++;
        @(negedge clk);
        pixel_req = 1'b0;
        n_checks++;
        if ({bus_f.oValid, bus_f.oRed, bus_f.oGreen, bus_f.oBlue} !== {1'b1, 10'h000, 10'h3E0, 10'h3FF})
            $display("FAIL unpack_rgb: got %h want %h", {bus_f.oValid, bus_f.oRed, bus_f.oGreen, bus_f.oBlue},
                     {1'b1, 10'h000, 10'h3E0, 10'h3FF});
        else n_pass++;
        n_checks++;
        if ({bus_f.oX_Cont, bus_f.oY_Cont} !== {16'd0, 16'd0})
            $display("FAIL unpack_xy0: got %h want 0", {bus_f.oX_Cont, bus_f.oY_Cont});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus_f.oValid, bus_f.oX_Cont, bus_f.oY_Cont} !== {1'b1, 16'd1, 16'd0})
            $display("FAIL unpack_xy1: got %h want %h", {bus_f.oValid, bus_f.oX_Cont, bus_f.oY_Cont},
                     {1'b1, 16'd1, 16'd0});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus_f.oValid !== 1'b0)
            $display("FAIL unpack_idle_valid: got %b want 0", bus_f.oValid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int valid_cnt = 0;
        int done_cnt = 0;
        pulse_reset();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        rd1_data = 16'h1234;
        rd2_data = 16'h4321;
        for (int k = 0; k < 12; k++) begin
            pixel_req = (k < 9);
            #1;
            if (k == 8) begin
                n_checks++;
                if ({bus_s.oRd1_req, bus_s.oRd2_req} !== 2'b00)
                    $display("FAIL b2b_pop_after_frame: got %b want 00", {bus_s.oRd1_req, bus_s.oRd2_req});
                else n_pass++;
            end
            @(negedge clk);
            if (bus_s.oValid === 1'b1) valid_cnt++;
            if (bus_s.oFrameDone === 1'b1) done_cnt++;
            if (k >= 1 && k <= 8) begin
                n_checks++;
                if ({bus_s.oValid, bus_s.oX_Cont, bus_s.oY_Cont} !== {1'b1, 16'((k - 1) % 4), 16'((k - 1) / 4)})
                    $display("FAIL b2b_xy[%0d]: got %h want %h", k - 1, {bus_s.oValid, bus_s.oX_Cont, bus_s.oY_Cont},
                             {1'b1, 16'((k - 1) % 4), 16'((k - 1) / 4)});
                else n_pass++;
                n_checks++;
                if (bus_s.oFrameDone !== (k == 8))
                    $display("FAIL b2b_done[%0d]: got %b want %b", k - 1, bus_s.oFrameDone, (k == 8));
                else n_pass++;
            end
            if (k == 1) begin
                n_checks++;
                if ({bus_s.oRed, bus_s.oGreen, bus_s.oBlue} !== RGB_1234)
                    $display("FAIL b2b_rgb: got %h want %h", {bus_s.oRed, bus_s.oGreen, bus_s.oBlue}, RGB_1234);
                else n_pass++;
            end
            if (k == 9) begin
                n_checks++;
                if (bus_s.oValid !== 1'b0)
                    $display("FAIL b2b_ninth_valid: got %b want 0", bus_s.oValid);
                else n_pass++;
            end
        end
        n_checks++;
        if (valid_cnt != 8)
            $display("FAIL b2b_valid_count: got %0d want 8", valid_cnt);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1)
            $display("FAIL b2b_done_count: got %0d want 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_underflow();
        logic [29:0] exp_rgb;
`ifdef UNDERFLOW_REPEAT_EN
        exp_rgb = RGB_1234;
`else
        exp_rgb = 30'h0;
`endif
        pulse_reset();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        rd1_data = 16'h1234;
        rd2_data = 16'h4321;
        for (int k = 0; k < 6; k++) begin
            pixel_req = (k < 4);
            rd2_empty = (k == 2);
            #1;
            if (k == 1) begin
                n_checks++;
                if ({bus_s.oRd1_req, bus_s.oRd2_req} !== 2'b11)
                    $display("FAIL uf_pop_ok: got %b want 11", {bus_s.oRd1_req, bus_s.oRd2_req});
                else n_pass++;
            end
            if (k == 2) begin
                n_checks++;
                if ({bus_s.oRd1_req, bus_s.oRd2_req} !== 2'b00)
                    $display("FAIL uf_no_pop: got %b want 00", {bus_s.oRd1_req, bus_s.oRd2_req});
                else n_pass++;
            end
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if (bus_s.oUnderflow !== 1'b0)
                    $display("FAIL uf_flag_early: got %b want 0", bus_s.oUnderflow);
                else n_pass++;
            end
            if (k == 2) begin
                n_checks++;
                if (bus_s.oUnderflow !== 1'b1)
                    $display("FAIL uf_flag_set: got %b want 1", bus_s.oUnderflow);
                else n_pass++;
            end
            if (k == 3) begin
                n_checks++;
                if ({bus_s.oValid, bus_s.oX_Cont, bus_s.oRed, bus_s.oGreen, bus_s.oBlue} !== {1'b1, 16'd2, exp_rgb})
                    $display("FAIL uf_pixel: got %h want %h",
                             {bus_s.oValid, bus_s.oX_Cont, bus_s.oRed, bus_s.oGreen, bus_s.oBlue}, {1'b1, 16'd2, exp_rgb});
                else n_pass++;
            end
            if (k == 4) begin
                n_checks++;
                if ({bus_s.oValid, bus_s.oRed, bus_s.oGreen, bus_s.oBlue} !== {1'b1, RGB_1234})
                    $display("FAIL uf_recover: got %h want %h",
                             {bus_s.oValid, bus_s.oRed, bus_s.oGreen, bus_s.oBlue}, {1'b1, RGB_1234});
                else n_pass++;
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus_s.oUnderflow !== 1'b1)
            $display("FAIL uf_sticky: got %b want 1", bus_s.oUnderflow);
        else n_pass++;
    endtask

    task automatic test_resync();
        int done_cnt = 0;
        pulse_reset();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            pixel_req = (k < 5) || (k == 6);
            frame_start = (k == 5);
            @(negedge clk);
            if (bus_f.oFrameDone === 1'b1) done_cnt++;
            if (k == 5) begin
                n_checks++;
                if ({bus_f.oValid, bus_f.oX_Cont, bus_f.oY_Cont} !== {1'b1, 16'd4, 16'd0})
                    $display("FAIL resync_pre: got %h want %h", {bus_f.oValid, bus_f.oX_Cont, bus_f.oY_Cont},
                             {1'b1, 16'd4, 16'd0});
                else n_pass++;
            end
            if (k == 7) begin
                n_checks++;
                if ({bus_f.oValid, bus_f.oX_Cont, bus_f.oY_Cont} !== {1'b1, 16'd0, 16'd0})
                    $display("FAIL resync_post: got %h want %h", {bus_f.oValid, bus_f.oX_Cont, bus_f.oY_Cont},
                             {1'b1, 16'd0, 16'd0});
                else n_pass++;
            end
        end
        frame_start = 1'b0;
        pixel_req = 1'b0;
        n_checks++;
        if (done_cnt != 0)
            $display("FAIL resync_no_done: got %0d pulses want 0", done_cnt);
        else n_pass++;
    endtask

    task automatic test_idle_req();
        pulse_reset();
        pixel_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++;
            if ({bus_f.oRd1_req, bus_f.oRd2_req, bus_f.oValid} !== 3'b000)
                $display("FAIL idle_req[%0d]: got %b want 000", k, {bus_f.oRd1_req, bus_f.oRd2_req, bus_f.oValid});
            else n_pass++;
            @(negedge clk);
        end
        frame_start = 1'b1;
        #1;
        n_checks++;
        if ({bus_f.oRd1_req, bus_f.oRd2_req} !== 2'b00)
            $display("FAIL start_req_pop: got %b want 00", {bus_f.oRd1_req, bus_f.oRd2_req});
        else n_pass++;
        @(negedge clk);
        frame_start = 1'b0;
        pixel_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (bus_f.oValid !== 1'b0)
                $display("FAIL start_req_valid: got %b want 0", bus_f.oValid);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        rd1_data = 16'h1234;
        rd2_data = 16'h4321;
        rd2_empty = 1'b1;
        pixel_req = 1'b1;
        @(negedge clk);
        rd2_empty = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_f.oUnderflow, bus_f.oValid} !== 2'b11)
            $display("FAIL rstmid_pre: got %b want 11", {bus_f.oUnderflow, bus_f.oValid});
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus_f.oValid, bus_f.oUnderflow, bus_f.oFrameDone, bus_f.oRd1_req, bus_f.oRd2_req} !== 5'b0)
            $display("FAIL rstmid_ctrl: got %b want 00000",
                     {bus_f.oValid, bus_f.oUnderflow, bus_f.oFrameDone, bus_f.oRd1_req, bus_f.oRd2_req});
        else n_pass++;
        n_checks++;
        if ({bus_f.oRed, bus_f.oGreen, bus_f.oBlue, bus_f.oX_Cont, bus_f.oY_Cont} !== 62'h0)
            $display("FAIL rstmid_data: got %h want 0",
                     {bus_f.oRed, bus_f.oGreen, bus_f.oBlue, bus_f.oX_Cont, bus_f.oY_Cont});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus_f.oRd1_req, bus_f.oRd2_req} !== 2'b00)
            $display("FAIL rstmid_idle: got %b want 00", {bus_f.oRd1_req, bus_f.oRd2_req});
        else n_pass++;
        pixel_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unpack();
        test_back_to_back();
        test_underflow();
        test_resync();
        test_idle_req();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_frame_reader.md
Name: display_frame_reader

Overview:
- Read-side counterpart of the camera write path: pops packed 2×16-bit pixel words from the two SDRAM read FIFOs and unpacks them to 10-bit R/G/B for the VGA controller.
- Paced by the display's per-pixel request.
- Tracks X/Y position, counts pixels per frame, and handles FIFO underflow.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame

Ports:
- iClk  in  1  pixel clock
- iRst  in  1  synchronous reset, active-high
- iFrameStart  in  1  one-cycle pulse at start of display frame
- iPixelReq  in  1  display requests one pixel this cycle
- iRd1_data  in  16  read FIFO 1 word, valid 1 cycle after pop
- iRd2_data  in  16  read FIFO 2 word, valid 1 cycle after pop
- iRd1_empty  in  1  FIFO 1 empty
- iRd2_empty  in  1  FIFO 2 empty
- oRd1_req  out  1  pop FIFO 1
- oRd2_req  out  1  pop FIFO 2
- oRed  out  10  unpacked red
- oGreen  out  10  unpacked green
- oBlue  out  10  unpacked blue
- oValid  out  1  R/G/B valid
- oX_Cont  out  16  column of current output pixel
- oY_Cont  out  16  row of current output pixel
- oFrameDone  out  1  one-cycle pulse after last pixel of frame
- oUnderflow  out  1  sticky underflow flag

Behaviour:
- Reset (iRst high at a clock edge): state IDLE, all outputs 0, counters 0, last-pixel register 0.
- FSM states and transitions:
  - IDLE: iFrameStart -> STREAM, counters cleared.
  - STREAM: counts pixels; after pixel (H_ACTIVE-1, V_ACTIVE-1) is issued -> DRAIN.
  - DRAIN: waits for the in-flight pixel to reach the outputs; pulses oFrameDone on the cycle oValid is high for the final pixel; -> IDLE next cycle.
- Pop rule:
  - oRd1_req = oRd2_req = iPixelReq & (state==STREAM) & ~iRd1_empty & ~iRd2_empty. This is combinational.
  - Both FIFOs are always popped together.
- Issue: any iPixelReq in STREAM is a pixel issue, whether popped or underflowed. It advances X; X wraps H_ACTIVE-1 -> 0 with Y+1.
- Latency: request at cycle n, FIFO data at n+1, registered unpack, so oValid/RGB/oX_Cont/oY_Cont at n+2. oX_Cont/oY_Cont are the issue coordinates delayed 2 cycles.
- Unpack format:
  - oBlue = rd1[9:0]
  - oRed = rd2[9:0]
  - oGreen = {rd1[14:10], rd2[14:10]}
  - bit 15 of both words ignored.
- Underflow: iPixelReq in STREAM with either FIFO empty.
  - No pop.
  - oValid still asserted at n+2 with RGB = 0.
  - oUnderflow set; cleared only by iRst.
- iPixelReq in IDLE or DRAIN is ignored: no pop, no oValid.
- iFrameStart during STREAM or DRAIN: resync. Counters go to 0 and state to STREAM. In-flight pixels still emerge at n+2 with their original coordinates. No oFrameDone for the aborted frame.
- iFrameStart and iPixelReq in the same cycle in IDLE: transition only, request ignored.
- Back-to-back requests every cycle sustain one pixel per clock.

Optional Feature:
- Macro UNDERFLOW_REPEAT_EN.
- Defined: an underflowed pixel outputs the last successfully unpacked RGB (0 if none since reset).
- Undefined: an underflowed pixel outputs black (0,0,0).
- oUnderflow behaviour is identical in both cases.

Decomposition:
- Package display_pkg:
  - state enum {IDLE, STREAM, DRAIN}
  - field constants: B_LSB=0, B_MSB=9, GHI_LSB=10, GHI_MSB=14, pixel width 10
  - default H_ACTIVE/V_ACTIVE
- Sub-module pixel_unpack: registered stage taking two 16-bit words plus an underflow flag, producing 30-bit RGB. Holds the last-pixel register when UNDERFLOW_REPEAT_EN is defined.

Test Plan:
1. Reset then iFrameStart; rd1=16'h7FFF, rd2=16'h0000, continuous req -> oBlue=10'h3FF, oGreen=10'h3E0, oRed=0; oValid 2 cycles after first req.
2. H_ACTIVE=4, V_ACTIVE=2, 8 consecutive reqs -> 8 oValid with (X,Y) sequence (0,0)..(3,0),(0,1)..(3,1); single oFrameDone coincident with the 8th oValid; 9th req produces no pop and no valid.
3. iRd2_empty=1 on 3rd req -> no oRd*_req that cycle; 3rd pixel RGB=0 (or equal to 2nd pixel with UNDERFLOW_REPEAT_EN); oUnderflow=1 and stays 1 until iRst.
4. iFrameStart after 5 pixels of a 640×480 frame -> next issued pixel has X=0,Y=0; no oFrameDone pulse.
5. iPixelReq held high in IDLE for 10 cycles -> oRd1_req/oRd2_req/oValid stay 0.
6. iRst asserted mid-STREAM -> next cycle all outputs 0 and state IDLE; oUnderflow cleared.
